emergency_preempt: RTL and testbench

EMERGENCY_PREEMPT -- requirements
Module: emergency_preempt

---
 rtl/emergency_preempt_pkg.sv | 41 ++++
 rtl/emergency_preempt_arbiter.sv | 26 ++
 rtl/emergency_preempt.sv | 153 +++++++++++++++
 tb/tb_emergency_preempt.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/emergency_preempt_pkg.sv
// Shared traffic package for the emergency preemption block: controller
// state encoding, per-lane light codes and default timing parameters.
package emergency_preempt_pkg;

  // Controller states; encodings 6 and 7 are unreachable and recover
  // through EXIT_ALLRED so the junction is always cleared first.
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    ENTRY_YELLOW = 3'd1,
    ENTRY_ALLRED = 3'd2,
    GREEN        = 3'd3,
    EXIT_YELLOW  = 3'd4,
    EXIT_ALLRED  = 3'd5
  } preemptState_t;

  // Two-bit light code per lane; 2'b11 is not a legal aspect.
  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  // Default timing, all in clocks; legal range is 1..255.
  localparam int DEF_YELLOW_CYCLES = 3;
  localparam int DEF_ALLRED_CYCLES = 2;
  localparam int DEF_MIN_GREEN     = 10;
  localparam int DEF_MAX_GREEN     = 30;

  // Eight lanes grouped into four approaches of two lanes each.
  localparam int NUM_LANES      = 8;
  localparam int NUM_APPROACHES = 4;

  // The illegal code must never reach a signal head; show it as red.
  function automatic logic [1:0] sanitizeCode(input logic [1:0] code);
    return (code == 2'b11) ? LIGHT_RED : code;
  endfunction

  // Lanes that were showing green or yellow need a yellow clearance.
  function automatic logic isMoving(input logic [1:0] code);
    return (code == LIGHT_GREEN) || (code == LIGHT_YELLOW);
  endfunction

endpackage

// File: rtl/emergency_preempt_arbiter.sv
// Four-way round-robin arbiter: the approach after the last grant has the
// highest priority, the last-granted approach itself the lowest.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] lastGrant,
  output logic       valid,
  output logic [1:0] grant
);

  logic [1:0] idx;

  // Scan from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    valid = 1'b0;
    grant = lastGrant;
    idx   = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      idx = lastGrant + 2'(i);
      if (req[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/emergency_preempt.sv
// Emergency-vehicle preemption controller. Sits between the normal signal
// controller and the signal heads: passes normal lights through while idle,
// otherwise clears the junction (yellow, all-red), gives a preemption green
// to one approach chosen round-robin, then clears again.
// Handshake: there is none; laneReq is a level request sampled every clock
// into reqQ and normalHold is a level that freezes the normal controller for
// as long as it is high. All outputs are registered.
module emergency_preempt
  import emergency_preempt_pkg::*;
#(
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  parameter int ALLRED_CYCLES = DEF_ALLRED_CYCLES,
  parameter int MIN_GREEN     = DEF_MIN_GREEN,
  parameter int MAX_GREEN     = DEF_MAX_GREEN
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [0:7]  laneReq,
  input  logic [0:15] normalLights,
  output logic [0:15] laneLights,
  output logic        preemptActive,
  output logic [1:0]  grantApproach,
  output logic        normalHold,
  output logic [2:0]  dbgState
);

  // The timer holds (clocks already spent in the state) - 1 at each edge,
  // so a state lasting N clocks ends when the timer reaches N-1.
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_CYCLES - 1);
  localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_CYCLES - 1);
  localparam logic [7:0] MIN_LAST    = 8'(MIN_GREEN - 1);
  localparam logic [7:0] MAX_LAST    = 8'(MAX_GREEN - 1);

  preemptState_t state;
  preemptState_t nextState;
  logic [7:0]    timer;
  logic [3:0]    reqA;
  logic [3:0]    reqQ;
  logic [0:15]   snap;
  logic [0:15]   snapSrc;
  logic [0:15]   lightsNext;
  logic [1:0]    grantNext;
  logic          arbValid;
  logic [1:0]    arbGrant;
  logic          otherReq;

  assign dbgState = state;

  // Collapse lane requests into per-approach requests.
  always_comb begin
    reqA = '0;
    for (int a = 0; a < NUM_APPROACHES; a++) begin
      reqA[a] = laneReq[2*a] | laneReq[2*a+1];
    end
  end

  assign otherReq = |(reqQ & ~(4'b0001 << grantApproach));

  rr_arbiter4 u_arb (
    .req       (reqQ),
    .lastGrant (grantApproach),
    .valid     (arbValid),
    .grant     (arbGrant)
  );

  // Next-state and grant selection.
  always_comb begin
    nextState = state;
    grantNext = grantApproach;
    case (state)
      IDLE: begin
        if (|reqQ) nextState = ENTRY_YELLOW;
      end
      ENTRY_YELLOW: begin
        if (timer >= YELLOW_LAST) nextState = ENTRY_ALLRED;
      end
      ENTRY_ALLRED, EXIT_ALLRED: begin
        if (timer >= ALLRED_LAST) begin
          if (arbValid) begin
            nextState = GREEN;
            grantNext = arbGrant;
          end else begin
            nextState = IDLE;
          end
        end
      end
      GREEN: begin
        if ((timer >= MIN_LAST && !reqQ[grantApproach]) ||
            (timer >= MAX_LAST && otherReq)) begin
          nextState = EXIT_YELLOW;
        end
      end
      EXIT_YELLOW: begin
        if (timer >= YELLOW_LAST) nextState = EXIT_ALLRED;
      end
      default: nextState = EXIT_ALLRED;
    endcase
  end

  // Light pattern for the state being entered; registered below so the
  // heads change on the same edge as the state.
  always_comb begin
    lightsNext = '0;
    snapSrc    = (state == IDLE) ? normalLights : snap;
    case (nextState)
      IDLE: begin
        for (int l = 0; l < NUM_LANES; l++) begin
          lightsNext[2*l +: 2] = sanitizeCode(normalLights[2*l +: 2]);
        end
      end
      ENTRY_YELLOW: begin
        for (int l = 0; l < NUM_LANES; l++) begin
          if (isMoving(snapSrc[2*l +: 2])) lightsNext[2*l +: 2] = LIGHT_YELLOW;
        end
      end
      GREEN:       lightsNext[{grantNext, 2'b00} +: 4] = {LIGHT_GREEN, LIGHT_GREEN};
      EXIT_YELLOW: lightsNext[{grantNext, 2'b00} +: 4] = {LIGHT_YELLOW, LIGHT_YELLOW};
      default:     lightsNext = '0;
    endcase
  end

  // State, timer, request sampling and the snapshot of the normal lights.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      timer <= '0;
      reqQ  <= '0;
      snap  <= '0;
    end else begin
      state <= nextState;
      reqQ  <= reqA;
      if (nextState != state) timer <= '0;
      else if (timer != 8'hFF) timer <= timer + 8'd1;
      if (state == IDLE && nextState == ENTRY_YELLOW) snap <= normalLights;
    end
  end

  // Registered outputs; grant 3 after reset so approach 0 wins first.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      laneLights    <= '0;
      preemptActive <= 1'b0;
      normalHold    <= 1'b0;
      grantApproach <= 2'd3;
    end else begin
      laneLights    <= lightsNext;
      preemptActive <= (nextState == GREEN);
      normalHold    <= (nextState != IDLE);
      grantApproach <= grantNext;
    end
  end

endmodule

// File: tb/tb_emergency_preempt.sv
// Bench for emergency_preempt: a phase/countdown model of the preemption
// sequence feeds an expected queue that is checked every cycle, plus
// directed scenarios with hand-computed light patterns.
module tb_emergency_preempt;

  localparam int YC   = 3;
  localparam int AR   = 2;
  localparam int MING = 10;
  localparam int MAXG = 30;
  localparam int W    = 20;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [0:7]  laneReq = '0;
  logic [0:15] normalLights = '0;
  logic [0:15] laneLights;
  logic        preemptActive;
  logic [1:0]  grantApproach;
  logic        normalHold;
  logic [2:0]  dbgState;

  int testsRun = 0;
  int testsFailed = 0;

  logic [W-1:0] exp_q[$];

  emergency_preempt #(
    .YELLOW_CYCLES (YC),
    .ALLRED_CYCLES (AR),
    .MIN_GREEN     (MING),
    .MAX_GREEN     (MAXG)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .laneReq       (laneReq),
    .normalLights  (normalLights),
    .laneLights    (laneLights),
    .preemptActive (preemptActive),
    .grantApproach (grantApproach),
    .normalHold    (normalHold),
    .dbgState      (dbgState)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Phases: 0 pass-through, 1 entry yellow, 2 entry all-red, 3 green,
  // 4 exit yellow, 5 exit all-red. mLeft counts clocks remaining.
  int          mPhase = 0;
  int          mLeft = 0;
  int          mGreen = 0;
  int          mGrant = 3;
  logic [3:0]  mReq = '0;
  logic [0:15] mSnap = '0;

  function automatic logic [0:15] modelLights(input int ph, input int g,
                                              input logic [0:15] sn, input logic [0:15] nl);
    logic [0:15] r;
    logic [1:0]  c;
    r = '0;
    for (int l = 0; l < 8; l++) begin
      if (ph == 0) begin
        c = nl[2*l +: 2];
        r[2*l +: 2] = (c == 2'b11) ? 2'b00 : c;
      end else if (ph == 1) begin
        c = sn[2*l +: 2];
        if (c == 2'b01 || c == 2'b10) r[2*l +: 2] = 2'b01;
      end else if ((ph == 3 || ph == 4) && (l / 2 == g)) begin
        r[2*l +: 2] = (ph == 3) ? 2'b10 : 2'b01;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge resetN) begin
    int winner;
    logic [3:0] others;
    if (!resetN) begin
      mPhase = 0; mLeft = 0; mGreen = 0; mGrant = 3; mReq = '0; mSnap = '0;
      exp_q.delete();
    end else begin
      case (mPhase)
        0: if (mReq != 0) begin mSnap = normalLights; mPhase = 1; mLeft = YC; end
        1: begin mLeft--; if (mLeft == 0) begin mPhase = 2; mLeft = AR; end end
        2, 5: begin
          mLeft--;
          if (mLeft == 0) begin
            winner = -1;
            for (int k = 1; k <= 4; k++)
              if (winner < 0 && mReq[(mGrant + k) % 4]) winner = (mGrant + k) % 4;
            if (winner >= 0) begin mPhase = 3; mGrant = winner; mGreen = 0; end
            else mPhase = 0;
          end
        end
        3: begin
          mGreen++;
          others = mReq & ~(4'b0001 << mGrant);
          if ((mGreen >= MING && !mReq[mGrant]) || (mGreen >= MAXG && others != 0)) begin
            mPhase = 4; mLeft = YC;
          end
        end
        default: begin mLeft--; if (mLeft == 0) begin mPhase = 5; mLeft = AR; end end
      endcase
      for (int a = 0; a < 4; a++) mReq[a] = laneReq[2*a] | laneReq[2*a+1];
      exp_q.push_back({modelLights(mPhase, mGrant, mSnap, normalLights),
                       (mPhase == 3), 2'(mGrant), (mPhase != 0)});
    end
  end

  // Every-cycle comparison against the model (or reset values in reset).
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!resetN) begin
      check("rst_lights", laneLights, 16'h0000);
      check("rst_active", preemptActive, 1'b0);
      check("rst_hold", normalHold, 1'b0);
      check("rst_grant", grantApproach, 2'd3);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("mdl_lights", laneLights, e[19:4]);
      check("mdl_active", preemptActive, e[3]);
      check("mdl_grant", grantApproach, e[2:1]);
      check("mdl_hold", normalHold, e[0]);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int idleSeen;
    resetN = 1'b0; laneReq = '0; normalLights = 16'h8000;
    step(2);
    check("reset_lights", laneLights, 16'h0000);
    check("reset_grant", grantApproach, 2'd3);
    check("reset_hold", normalHold, 1'b0);
    @(posedge clk); #2 resetN = 1'b1;

    // Pass-through after reset.
    step(2);
    check("pass_lights", laneLights, 16'h8000);
    check("pass_hold", normalHold, 1'b0);
    normalLights = 16'hF0A5;
    step(1);
    check("pass_sanitize", laneLights, 16'h00A5);

    // Approach 1 request, lane0 green and lane1 yellow in the snapshot.
    normalLights = 16'h9000; laneReq = 8'h30;
    step(2);
    check("entry_yellow1", laneLights, 16'h5000);
    check("entry_hold", normalHold, 1'b1);
    normalLights = 16'h2000;
    step(2);
    check("entry_yellow3", laneLights, 16'h5000);
    step(1);
    check("entry_allred1", laneLights, 16'h0000);
    step(1);
    check("entry_allred2", laneLights, 16'h0000);
    step(1);
    check("green1_lights", laneLights, 16'h0A00);
    check("green1_grant", grantApproach, 2'd1);
    check("green1_active", preemptActive, 1'b1);

    // Drop after 4 green clocks: green still lasts 10 clocks.
    step(3); laneReq = '0;
    step(6);
    check("green_min_held", laneLights, 16'h0A00);
    step(1);
    check("exit_yellow1", laneLights, 16'h0500);
    check("exit_inactive", preemptActive, 1'b0);
    step(2);
    check("exit_yellow3", laneLights, 16'h0500);
    step(1);
    check("exit_allred1", laneLights, 16'h0000);
    step(1);
    check("exit_allred_hold", normalHold, 1'b1);
    step(1);
    check("back_idle_lights", laneLights, 16'h2000);
    check("back_idle_hold", normalHold, 1'b0);

    // Approaches 0, 1, 3 requesting after grant 1: approach 3 wins.
    laneReq = 8'h62;
    step(2);
    check("rr_entry_yellow", laneLights, 16'h1000);
    step(5);
    check("rr_lights", laneLights, 16'h000A);
    check("rr_grant", grantApproach, 2'd3);

    // Reset pulse during green takes effect without a clock edge.
    step(2);
    @(posedge clk); #2 resetN = 1'b0; laneReq = '0;
    #1;
    check("async_lights", laneLights, 16'h0000);
    check("async_active", preemptActive, 1'b0);
    check("async_hold", normalHold, 1'b0);
    check("async_state", dbgState, 3'd0);
    @(posedge clk); #2 resetN = 1'b1; normalLights = 16'h8000;
    step(2);
    check("resume_lights", laneLights, 16'h8000);
    check("resume_hold", normalHold, 1'b0);

    // Approaches 0 and 2 held: 0 capped at 30 clocks, then 2, no idle.
    laneReq = 8'h84;
    step(7);
    check("cap_green0", laneLights, 16'hA000);
    check("cap_grant0", grantApproach, 2'd0);
    idleSeen = 0;
    for (int i = 8; i <= 42; i++) begin
      step(1);
      if (!normalHold) idleSeen++;
      if (i == 36) check("cap_green_last", laneLights, 16'hA000);
      if (i == 37) check("cap_exit_yellow", laneLights, 16'h5000);
    end
    check("cap_no_idle", idleSeen, 0);
    check("cap_green2", laneLights, 16'h00A0);
    check("cap_grant2", grantApproach, 2'd2);
    laneReq = '0;
    step(16);
    check("cap_done_hold", normalHold, 1'b0);
    check("cap_done_lights", laneLights, 16'h8000);

    // One-clock request: entry sequence completes, then back to idle.
    laneReq = 8'h40;
    step(1); laneReq = '0;
    step(1);
    check("pulse_yellow", laneLights, 16'h4000);
    step(4);
    check("pulse_allred_hold", normalHold, 1'b1);
    step(1);
    check("pulse_idle_hold", normalHold, 1'b0);
    check("pulse_idle_lights", laneLights, 16'h8000);

    step(2);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
